// File: rtl/iagc_pkg.sv
// Shared IAGC constants, gain type and the slew helper used by gain_stage.
// Included by every gain_stage file via import iagc_pkg::*.
package iagc_pkg;

    localparam logic [3:0] IAGC_STATUS_RUNNING = 4'h4;

    localparam int GAIN_WIDTH   = 16;
    localparam int LANE_WIDTH   = 16;
    localparam int SAMPLE_WIDTH = 14;
    localparam int SAMPLE_MIN   = -8192;
    localparam int SAMPLE_MAX   = 8191;

    typedef logic [GAIN_WIDTH-1:0] gain_t;

    localparam gain_t GAIN_UNITY = 16'h0100;

    // Move current toward target by at most step; clamping to the distance
    // keeps the gain from ever wrapping past the target.
    function automatic gain_t slew_toward(input gain_t current, input gain_t target,
                                          input gain_t step);
        gain_t distance;
        gain_t result;
        if (target >= current) begin
            distance = target - current;
            result   = current + ((distance < step) ? distance : step);
        end else begin
            distance = current - target;
            result   = current - ((distance < step) ? distance : step);
        end
        return result;
    endfunction

endpackage

// File: rtl/gain_stage_if.sv
// Sample/gain bus between adc/processor and gain_stage. The optional saturation
// counter output exists only when GAIN_STAGE_SAT_COUNT_EN is defined.
interface gain_stage_if #(
    parameter int AXIS_DATA_SIZE   = 32,
    parameter int QUOTIENT_SIZE    = 8,
    parameter int FRACTIONAL_SIZE  = 8,
    parameter int IAGC_STATUS_SIZE = 4
);

    logic [IAGC_STATUS_SIZE-1:0]              i_iagcStatus;
    logic [QUOTIENT_SIZE-1:0]                 i_quotient;
    logic [FRACTIONAL_SIZE-1:0]               i_fractional;
    logic                                     i_gainValid;
    logic [AXIS_DATA_SIZE-1:0]                i_data;
    logic                                     i_dataValid;
    logic [AXIS_DATA_SIZE-1:0]                o_data;
    logic                                     o_dataValid;
    logic [QUOTIENT_SIZE+FRACTIONAL_SIZE-1:0] o_gain;
    logic                                     o_ramping;
`ifdef GAIN_STAGE_SAT_COUNT_EN
    logic [15:0]                              o_satCount;

    modport master (
        output i_iagcStatus, i_quotient, i_fractional, i_gainValid, i_data, i_dataValid,
        input  o_data, o_dataValid, o_gain, o_ramping, o_satCount
    );

    modport slave (
        input  i_iagcStatus, i_quotient, i_fractional, i_gainValid, i_data, i_dataValid,
        output o_data, o_dataValid, o_gain, o_ramping, o_satCount
    );
`else
    modport master (
        output i_iagcStatus, i_quotient, i_fractional, i_gainValid, i_data, i_dataValid,
        input  o_data, o_dataValid, o_gain, o_ramping
    );

    modport slave (
        input  i_iagcStatus, i_quotient, i_fractional, i_gainValid, i_data, i_dataValid,
        output o_data, o_dataValid, o_gain, o_ramping
    );
`endif

endinterface

// File: rtl/gain_lane_mul.sv
// One channel of the gain datapath: registered signed x unsigned multiply, then
// registered round-half-up, shift and saturate. o_clip flags the word being emitted.
module gain_lane_mul
    import iagc_pkg::*;
#(
    parameter int SAMPLE_SIZE     = SAMPLE_WIDTH,
    parameter int GAIN_SIZE       = GAIN_WIDTH,
    parameter int FRACTIONAL_SIZE = 8,
    parameter int SAT_MIN         = SAMPLE_MIN,
    parameter int SAT_MAX         = SAMPLE_MAX
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_load,
    input  logic                          i_emit,
    input  logic signed [SAMPLE_SIZE-1:0] i_sample,
    input  logic [GAIN_SIZE-1:0]          i_gain,
    output logic signed [SAMPLE_SIZE-1:0] o_result,
    output logic                          o_clip
);

    localparam int PRODUCT_SIZE = SAMPLE_SIZE + GAIN_SIZE + 1;
    localparam int SUM_SIZE     = PRODUCT_SIZE + 1;

    localparam logic signed [SUM_SIZE-1:0] ROUND_BIAS = SUM_SIZE'(1) << (FRACTIONAL_SIZE - 1);
    localparam logic signed [SUM_SIZE-1:0] LIMIT_HI   = SUM_SIZE'(SAT_MAX);
    localparam logic signed [SUM_SIZE-1:0] LIMIT_LO   = SUM_SIZE'(SAT_MIN);

    logic signed [PRODUCT_SIZE-1:0] product;
    logic signed [SUM_SIZE-1:0]     rounded;
    logic signed [SUM_SIZE-1:0]     shifted;
    logic signed [SAMPLE_SIZE-1:0]  saturated;

    // The gain is zero-extended so the multiply stays signed without
    // reinterpreting gains >= 128.0 as negative.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            product <= '0;
        end else if (i_load) begin
            product <= PRODUCT_SIZE'(i_sample) * PRODUCT_SIZE'($signed({1'b0, i_gain}));
        end
    end

    always_comb begin
        rounded   = SUM_SIZE'(product) + ROUND_BIAS;
        shifted   = rounded >>> FRACTIONAL_SIZE;
        saturated = shifted[SAMPLE_SIZE-1:0];
        o_clip    = 1'b0;
        if (shifted > LIMIT_HI) begin
            saturated = LIMIT_HI[SAMPLE_SIZE-1:0];
            o_clip    = 1'b1;
        end else if (shifted < LIMIT_LO) begin
            saturated = LIMIT_LO[SAMPLE_SIZE-1:0];
            o_clip    = 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_result <= '0;
        end else if (i_emit) begin
            o_result <= saturated;
        end
    end

endmodule

// File: rtl/gain_stage.sv
// Applies the slew-limited IAGC Q8.8 gain to both ADC lanes ahead of the DAC.
// Define GAIN_STAGE_SAT_COUNT_EN to add the o_satCount clipped-lane counter.
module gain_stage
    import iagc_pkg::*;
#(
    parameter int ZMOD_DATA_SIZE   = 14,
    parameter int AXIS_DATA_SIZE   = 32,
    parameter int QUOTIENT_SIZE    = 8,
    parameter int FRACTIONAL_SIZE  = 8,
    parameter int IAGC_STATUS_SIZE = 4,
    parameter int SLEW_STEP        = 16,
    parameter int UPDATE_PERIOD    = 1000
) (
    input logic        i_clock,
    input logic        i_reset,
    gain_stage_if.slave bus
);

    localparam int GAIN_SIZE   = QUOTIENT_SIZE + FRACTIONAL_SIZE;
    localparam int LANE_SIZE   = AXIS_DATA_SIZE / 2;
    localparam int PAD_SIZE    = LANE_SIZE - ZMOD_DATA_SIZE;
    localparam int TIMER_WIDTH = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;

    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(UPDATE_PERIOD - 1);
    localparam logic [GAIN_SIZE-1:0]   STEP_SIZE  = GAIN_SIZE'(SLEW_STEP);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RAMP = 1'b1;

    logic [0:0]             state;
    logic [TIMER_WIDTH-1:0] timer;
    logic [GAIN_SIZE-1:0]   gain;
    logic [GAIN_SIZE-1:0]   target;
    logic [GAIN_SIZE-1:0]   next_target;
    logic [GAIN_SIZE-1:0]   stepped_gain;
    logic                   running;
    logic                   terminal;

    assign running      = (bus.i_iagcStatus == IAGC_STATUS_SIZE'(IAGC_STATUS_RUNNING));
    assign next_target  = bus.i_gainValid ? {bus.i_quotient, bus.i_fractional} : target;
    assign stepped_gain = slew_toward(gain, next_target, STEP_SIZE);
    assign terminal     = (timer == TIMER_LAST);

    // A retarget takes effect in the cycle it arrives, so both the exit test and
    // the step use next_target rather than the registered target.
    always_ff @(posedge i_clock) begin
        if (i_reset || !running) begin
            state  <= ST_IDLE;
            timer  <= '0;
            gain   <= GAIN_UNITY;
            target <= GAIN_UNITY;
        end else begin
            target <= next_target;
            case (state)
                ST_IDLE: begin
                    if (bus.i_gainValid && (next_target != gain)) begin
                        state <= ST_RAMP;
                        timer <= '0;
                    end
                end
                ST_RAMP: begin
                    if (next_target == gain) begin
                        state <= ST_IDLE;
                        timer <= '0;
                    end else if (terminal) begin
                        gain  <= stepped_gain;
                        timer <= '0;
                        if (stepped_gain == next_target) begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

    logic valid_s1;
    logic valid_s2;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            valid_s1 <= 1'b0;
            valid_s2 <= 1'b0;
        end else begin
            valid_s1 <= bus.i_dataValid;
            valid_s2 <= valid_s1;
        end
    end

    logic signed [ZMOD_DATA_SIZE-1:0] ch1_sample;
    logic signed [ZMOD_DATA_SIZE-1:0] ch2_sample;
    logic signed [ZMOD_DATA_SIZE-1:0] ch1_result;
    logic signed [ZMOD_DATA_SIZE-1:0] ch2_result;
    logic                             ch1_clip;
    logic                             ch2_clip;
    logic                             unused_pad_bits;

    assign ch1_sample      = bus.i_data[LANE_SIZE +: ZMOD_DATA_SIZE];
    assign ch2_sample      = bus.i_data[0 +: ZMOD_DATA_SIZE];
    assign unused_pad_bits = ^{bus.i_data[AXIS_DATA_SIZE-1 -: PAD_SIZE],
                               bus.i_data[LANE_SIZE-1 -: PAD_SIZE]};

    gain_lane_mul #(
        .SAMPLE_SIZE    (ZMOD_DATA_SIZE),
        .GAIN_SIZE      (GAIN_SIZE),
        .FRACTIONAL_SIZE(FRACTIONAL_SIZE),
        .SAT_MIN        (SAMPLE_MIN),
        .SAT_MAX        (SAMPLE_MAX)
    ) lane_ch1 (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_load  (bus.i_dataValid),
        .i_emit  (valid_s1),
        .i_sample(ch1_sample),
        .i_gain  (gain),
        .o_result(ch1_result),
        .o_clip  (ch1_clip)
    );

    gain_lane_mul #(
        .SAMPLE_SIZE    (ZMOD_DATA_SIZE),
        .GAIN_SIZE      (GAIN_SIZE),
        .FRACTIONAL_SIZE(FRACTIONAL_SIZE),
        .SAT_MIN        (SAMPLE_MIN),
        .SAT_MAX        (SAMPLE_MAX)
    ) lane_ch2 (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_load  (bus.i_dataValid),
        .i_emit  (valid_s1),
        .i_sample(ch2_sample),
        .i_gain  (gain),
        .o_result(ch2_result),
        .o_clip  (ch2_clip)
    );

    assign bus.o_data      = {{PAD_SIZE{ch1_result[ZMOD_DATA_SIZE-1]}}, ch1_result,
                              {PAD_SIZE{ch2_result[ZMOD_DATA_SIZE-1]}}, ch2_result};
    assign bus.o_dataValid = valid_s2;
    assign bus.o_gain      = gain;
    assign bus.o_ramping   = (state == ST_RAMP);

`ifdef GAIN_STAGE_SAT_COUNT_EN
    logic [15:0] sat_count;
    logic [16:0] sat_sum;

    assign sat_sum = {1'b0, sat_count} + {15'b0, ch1_clip} + {15'b0, ch2_clip};

    // Counted as the clipped word is registered into o_data; sticks at all-ones.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            sat_count <= '0;
        end else if (valid_s1) begin
            sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
        end
    end

    assign bus.o_satCount = sat_count;
`else
    logic unused_clip;
    assign unused_clip = ch1_clip ^ ch2_clip;
`endif

endmodule

// File: tb/tb_gain_stage.sv
// Self-checking bench for gain_stage: directed ramp/scaling/gating cases followed
// by randomized traffic, all compared against a behavioural model of the block.
module tb_gain_stage;

    localparam int UPDATE_PERIOD = 4;
    localparam int SLEW_STEP     = 16;
    localparam logic [3:0] RUN   = 4'h4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    gain_stage_if bus ();

    gain_stage #(
        .UPDATE_PERIOD(UPDATE_PERIOD),
        .SLEW_STEP    (SLEW_STEP)
    ) dut (
        .i_clock(clock),
        .i_reset(reset),
        .bus    (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model state
    int          mGain     = 256;
    int          mTarget   = 256;
    bit          mRamping  = 1'b0;
    int          mElapsed  = 0;
    bit          s1Valid   = 1'b0;
    logic [31:0] s1Data    = '0;
    int          s1Gain    = 256;
    bit          expValid  = 1'b0;
    logic [31:0] expData   = '0;
    int          expSat    = 0;
    logic [3:0]  curStatus = RUN;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Exact rounded value of sample*gain/256 with ties toward +inf (floor of x+0.5).
    function automatic longint roundedProduct(input logic [15:0] lane, input int gain);
        logic signed [13:0] s;
        longint num;
        longint q;
        s   = lane[13:0];
        num = longint'(s) * longint'(gain) + 128;
        q   = num / 256;
        if (num < 0 && (num % 256) != 0) q = q - 1;
        return q;
    endfunction

    task automatic modelStep(input bit rst, input logic [3:0] status, input bit gv,
                             input logic [15:0] tgt, input logic [31:0] data, input bit dv);
        longint r1;
        longint r2;
        int clips;
        int diff;
        if (rst) begin
            mGain = 256; mTarget = 256; mRamping = 0; mElapsed = 0;
            s1Valid = 0; expValid = 0; expData = '0; expSat = 0;
        end else begin
            if (s1Valid) begin
                r1 = roundedProduct(s1Data[31:16], s1Gain);
                r2 = roundedProduct(s1Data[15:0], s1Gain);
                clips = 0;
                if (r1 > 8191) begin r1 = 8191; clips++; end
                else if (r1 < -8192) begin r1 = -8192; clips++; end
                if (r2 > 8191) begin r2 = 8191; clips++; end
                else if (r2 < -8192) begin r2 = -8192; clips++; end
                expData  = {16'(r1), 16'(r2)};
                expSat   = (expSat + clips > 65535) ? 65535 : expSat + clips;
                expValid = 1;
            end else begin
                expValid = 0;
            end
            s1Valid = dv;
            s1Data  = data;
            s1Gain  = mGain;

            if (status != RUN) begin
                mGain = 256; mTarget = 256; mRamping = 0;
            end else begin
                if (gv) mTarget = int'(tgt);
                if (!mRamping) begin
                    if (gv && mTarget != mGain) begin
                        mRamping = 1;
                        mElapsed = 0;
                    end
                end else if (mTarget == mGain) begin
                    mRamping = 0;
                end else begin
                    mElapsed++;
                    if (mElapsed % UPDATE_PERIOD == 0) begin
                        diff = (mTarget > mGain) ? mTarget - mGain : mGain - mTarget;
                        if (diff > SLEW_STEP) diff = SLEW_STEP;
                        mGain = (mTarget > mGain) ? mGain + diff : mGain - diff;
                        if (mGain == mTarget) mRamping = 0;
                    end
                end
            end
        end
    endtask

    task automatic applyStimulus(input bit rst, input logic [3:0] status, input bit gv,
                                 input logic [15:0] tgt, input logic [31:0] data, input bit dv);
        reset            = rst;
        bus.i_iagcStatus = status;
        bus.i_gainValid  = gv;
        bus.i_quotient   = tgt[15:8];
        bus.i_fractional = tgt[7:0];
        bus.i_data       = data;
        bus.i_dataValid  = dv;
        @(posedge clock);
        modelStep(rst, status, gv, tgt, data, dv);
        #1;
        checkOutput("valid",   32'(bus.o_dataValid), 32'(expValid));
        checkOutput("data",    bus.o_data,           expData);
        checkOutput("gain",    32'(bus.o_gain),      32'(mGain));
        checkOutput("ramping", 32'(bus.o_ramping),   32'(mRamping));
`ifdef GAIN_STAGE_SAT_COUNT_EN
        checkOutput("satcount", 32'(bus.o_satCount), 32'(expSat));
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, curStatus, 0, 16'h0, 32'h0, 0);
    endtask

    task automatic setTarget(input logic [15:0] tgt);
        applyStimulus(0, curStatus, 1, tgt, 32'h0, 0);
    endtask

    task automatic sendSample(input int ch1, input int ch2);
        applyStimulus(0, curStatus, 0, 16'h0, {16'(ch1), 16'(ch2)}, 1);
    endtask

    initial begin
        int rampHigh;
        int notRunLeft;
        int satBefore;
        int pick;
        int t;
        logic [3:0] st;
        logic [15:0] tgt;

        bus.i_iagcStatus = RUN;
        bus.i_gainValid  = 0;
        bus.i_quotient   = '0;
        bus.i_fractional = '0;
        bus.i_data       = '0;
        bus.i_dataValid  = 0;

        applyStimulus(1, RUN, 0, 16'h0, 32'h0, 0);
        applyStimulus(1, RUN, 0, 16'h0, 32'h0, 0);
        checkOutput("reset_gain",    32'(bus.o_gain),      32'h0100);
        checkOutput("reset_valid",   32'(bus.o_dataValid), 32'h0);
        checkOutput("reset_data",    bus.o_data,           32'h0);
        checkOutput("reset_ramping", 32'(bus.o_ramping),   32'h0);

        sendSample(1000, -1000);
        idle(1);
        checkOutput("unity_data",  bus.o_data,           32'h03E8_FC18);
        checkOutput("unity_valid", 32'(bus.o_dataValid), 32'h1);

        setTarget(16'h0140);
        rampHigh = 32'(bus.o_ramping);
        for (int i = 1; i <= 16; i++) begin
            idle(1);
            rampHigh += 32'(bus.o_ramping);
            if (i % 4 == 0) checkOutput("ramp_step", 32'(bus.o_gain), 32'(256 + 16 * (i / 4)));
        end
        checkOutput("ramp_cycles", 32'(rampHigh), 32'd16);

        setTarget(16'h0180);
        idle(16);
        checkOutput("gain_0180", 32'(bus.o_gain), 32'h0180);
        sendSample(3, -3);
        idle(1);
        checkOutput("round_data", bus.o_data, 32'h0005_FFFC);

        setTarget(16'h0200);
        idle(32);
        checkOutput("gain_0200", 32'(bus.o_gain), 32'h0200);
        satBefore = expSat;
        sendSample(5000, -5000);
        idle(1);
        checkOutput("sat_data", bus.o_data, 32'h1FFF_E000);
`ifdef GAIN_STAGE_SAT_COUNT_EN
        checkOutput("sat_delta", 32'(bus.o_satCount), 32'(satBefore + 2));
`else
        if (satBefore < 0) $display("[TB] unexpected model counter");
`endif

        setTarget(16'h0100);
        idle(64);
        checkOutput("back_unity", 32'(bus.o_gain), 32'h0100);
        setTarget(16'h0108);
        idle(4);
        checkOutput("clamp_gain", 32'(bus.o_gain),    32'h0108);
        checkOutput("clamp_idle", 32'(bus.o_ramping), 32'h0);
        setTarget(16'h0100);
        idle(4);

        setTarget(16'h0140);
        idle(8);
        checkOutput("retarget_mid", 32'(bus.o_gain), 32'h0120);
        setTarget(16'h0100);
        idle(3);
        checkOutput("retarget_down1", 32'(bus.o_gain), 32'h0110);
        idle(4);
        checkOutput("retarget_down2", 32'(bus.o_gain),    32'h0100);
        checkOutput("retarget_idle",  32'(bus.o_ramping), 32'h0);

        setTarget(16'h0140);
        idle(4);
        setTarget(16'h0110);
        checkOutput("retarget_equal_gain", 32'(bus.o_gain),    32'h0110);
        checkOutput("retarget_equal_idle", 32'(bus.o_ramping), 32'h0);

        setTarget(16'h0140);
        idle(5);
        curStatus = 4'h2;
        idle(1);
        checkOutput("gate_gain", 32'(bus.o_gain),    32'h0100);
        checkOutput("gate_idle", 32'(bus.o_ramping), 32'h0);
        setTarget(16'h0180);
        idle(2);
        curStatus = RUN;
        idle(2);
        checkOutput("gate_ignored_gain", 32'(bus.o_gain),    32'h0100);
        checkOutput("gate_ignored_ramp", 32'(bus.o_ramping), 32'h0);

        notRunLeft = 0;
        for (int i = 0; i < 3000; i++) begin
            if (notRunLeft > 0) begin
                t = int'($urandom_range(0, 14));
                if (t >= 4) t++;
                st = 4'(t);
                notRunLeft--;
            end else begin
                st = RUN;
                if ($urandom_range(0, 99) == 0) notRunLeft = int'($urandom_range(1, 5));
            end
            pick = int'($urandom_range(0, 3));
            case (pick)
                0: begin
                    t = mGain + int'($urandom_range(0, 96)) - 48;
                    if (t < 0) t = 0;
                    if (t > 65535) t = 65535;
                    tgt = 16'(t);
                end
                1:       tgt = 16'h0000;
                2:       tgt = 16'($urandom);
                default: tgt = 16'(mGain);
            endcase
            applyStimulus($urandom_range(0, 999) < 3, st, $urandom_range(0, 99) < 4, tgt,
                          $urandom, $urandom_range(0, 9) < 7);
        end

        idle(1);
        sendSample(100, 200);
        sendSample(300, -400);
        applyStimulus(1, RUN, 0, 16'h0, 32'h0, 0);
        checkOutput("midreset_valid", 32'(bus.o_dataValid), 32'h0);
        checkOutput("midreset_data",  bus.o_data,           32'h0);
        checkOutput("midreset_gain",  32'(bus.o_gain),      32'h0100);
`ifdef GAIN_STAGE_SAT_COUNT_EN
        checkOutput("midreset_sat", 32'(bus.o_satCount), 32'h0);
`endif
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
